dcache_req_adapter: RTL and testbench
=====================================

Name: dcache_req_adapter

Overview:
- Sits directly downstream of the MEM stage, on its D$ port. Converts the MEM stage's level-held request (dc_en held until done) into single valid/ready request transactions to the data cache, and returns level-held completion flags to the MEM stage.
- Aligns store data and generates byte strobes, since the MEM stage sends store data unshifted. Returns the full aligned 64-bit word on loads; the MEM stage does the shifting.
- Detects a write_en change inside one instruction (atomic read then write) as a new request.

Parameters:
ADDR_WIDTH, 64, address width on both sides
DATA_WIDTH, 64, data width; only 64 is supported
STRB_WIDTH, DATA_WIDTH/8, number of byte strobes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dc_en  in  1  MEM request active (level)
dc_in_addr  in  ADDR_WIDTH  byte address
dc_write_en  in  1  1 = store, 0 = load
dc_in_wdata  in  64  store data, LSB-justified
dc_in_wlen  in  2  log2 of access bytes (3 = 8 bytes)
advance  in  1  MEM instruction retires this cycle
dc_out_rdata  out  64  aligned 64-bit word from the cache
dc_out_rvalid  out  1  load complete (level)
dc_out_write_done  out  1  store complete (level)
dc_out_misaligned  out  1  request is not naturally aligned; nothing is issued
c_req_valid  out  1  cache request valid
c_req_ready  in  1  cache accepts the request
c_req_addr  out  ADDR_WIDTH  dc_in_addr with bits [2:0] forced to 0
c_req_write  out  1  request is a write
c_req_wdata  out  64  shifted store data
c_req_wstrb  out  STRB_WIDTH  byte enables; all 0 for reads
c_resp_valid  in  1  one-cycle response, for both reads and writes
c_resp_rdata  in  64  read data; ignored for writes

Behaviour:
- Reset: state = IDLE; all outputs 0; abort flag cleared.
- Definitions:
  - off = addr[2:0]; size = 1 << wlen.
  - Misaligned = (addr & (size-1)) != 0.
  - strb = ((1 << size) - 1) << off.
  - wdata = dc_in_wdata << (8*off).
- dc_out_misaligned = dc_en && misaligned. It is combinational and is driven in any state.
- A misaligned request never leaves IDLE.
- States:
  - IDLE
    - dc_en && !misaligned: capture addr, write, wdata, strb; go to REQ.
  - REQ
    - c_req_valid = 1, with the captured fields held stable.
    - c_req_valid && c_req_ready: go to WAIT.
    - The adapter never drops valid before the handshake.
  - WAIT
    - c_resp_valid && !abort: latch c_resp_rdata into dc_out_rdata (reads only); go to DONE.
    - c_resp_valid && abort: discard the response; clear abort; go to IDLE.
  - DONE
    - dc_out_rvalid = !cap_write; dc_out_write_done = cap_write.
    - advance: go to IDLE; flags drop the next cycle.
    - Else if !dc_en: go to IDLE.
    - Else if dc_write_en != cap_write: capture the new request and go to REQ; flags drop the next cycle.
    - Else: stay in DONE with flags held.
- Abort: dc_en deasserting in REQ or WAIT (trap or flush) sets abort. The transaction still completes on the cache side and the response is not reported.
- New requests are ignored while abort is set; they are taken only from IDLE.
- Latency: dc_en is sampled in IDLE at cycle 0. c_req_valid asserts at cycle 1. With ready=1 and a one-cycle cache response at cycle 2, rvalid asserts at cycle 3.
- advance in the same cycle that DONE is entered cannot occur, because the MEM stage stalls until the flag is seen. If it does occur, it is ignored.
- dc_out_rdata holds its last value until the next read response.
- Reset mid-transaction returns to IDLE immediately. The cache is responsible for absorbing any orphan response.

Test Plan:
- Load: wlen=3, addr=0x1000, ready=1, resp one cycle later with rdata=0x1122334455667788. Required: c_req_addr=0x1000 with wstrb=0 at cycle 1; rvalid=1 with rdata=0x1122334455667788 at cycle 3, held until advance.
- Byte store: addr=0x2005, wlen=0, wdata=0xAB. Required: c_req_addr=0x2000, wstrb=0x20, wdata=0x0000AB0000000000; write_done=1 after the response.
- Backpressure: ready=0 for 4 cycles. Required: valid stays 1 with constant addr/wdata; exactly one handshake; one completion.
- Misaligned: addr=0x3002, wlen=2. Required: misaligned=1; c_req_valid never asserts.
- Atomic: read completes and DONE holds rvalid; then dc_write_en rises with the same addr. Required: a second request with c_req_write=1; rvalid drops; write_done rises after the second response.
- Abort: dc_en drops while in WAIT. Required: the response is swallowed, no rvalid; the next dc_en is accepted only after IDLE is reached.

Source files
------------

// File: rtl/dcache_req_if.sv
// Cache-side request/response bus of the D$ request adapter.
// The adapter drives the request side (master); the data cache drives
// ready and the one-cycle response (slave).
interface dcache_req_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  c_req_valid;
   logic                  c_req_ready;
   logic [ADDR_WIDTH-1:0] c_req_addr;
   logic                  c_req_write;
   logic [DATA_WIDTH-1:0] c_req_wdata;
   logic [STRB_WIDTH-1:0] c_req_wstrb;
   logic                  c_resp_valid;
   logic [DATA_WIDTH-1:0] c_resp_rdata;

   modport master (
      output c_req_valid, c_req_addr, c_req_write, c_req_wdata, c_req_wstrb,
      input  c_req_ready, c_resp_valid, c_resp_rdata
   );

   modport slave (
      input  c_req_valid, c_req_addr, c_req_write, c_req_wdata, c_req_wstrb,
      output c_req_ready, c_resp_valid, c_resp_rdata
   );
endinterface

// File: rtl/dcache_req_adapter.sv
// D$ request adapter: turns the MEM stage's level-held request into a single
// valid/ready cache transaction, aligns store data and strobes, and returns
// level-held completion flags. A request dropped mid-flight (trap/flush) is
// still completed on the cache side but its response is swallowed.
module dcache_req_adapter #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dc_en,
   input  logic [ADDR_WIDTH-1:0] dc_in_addr,
   input  logic                  dc_write_en,
   input  logic [DATA_WIDTH-1:0] dc_in_wdata,
   input  logic [1:0]            dc_in_wlen,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] dc_out_rdata,
   output logic                  dc_out_rvalid,
   output logic                  dc_out_write_done,
   output logic                  dc_out_misaligned,
   dcache_req_if.master          cache
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_mask(input logic [1:0] wlen);
      logic [2:0] m;
      case (wlen)
         2'd0:    m = 3'b000;
         2'd1:    m = 3'b001;
         2'd2:    m = 3'b011;
         2'd3:    m = 3'b111;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

   // Byte enables for an access of 2^wlen bytes starting at byte offset off.
   function automatic logic [STRB_WIDTH-1:0] byte_strb(input logic [1:0] wlen,
                                                       input logic [2:0] off);
      logic [STRB_WIDTH-1:0] base;
      case (wlen)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         2'd3:    base = 8'hFF;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   state_e                state_q, state_d;
   logic                  abort_q, abort_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  valid_q, valid_d;
   logic                  rvalid_q, rvalid_d;
   logic                  wdone_q, wdone_d;
   logic                  misaligned_s;
   logic                  capture_s;
   logic                  abort_now_s;

   assign misaligned_s      = (dc_in_addr[2:0] & size_mask(dc_in_wlen)) != 3'b000;
   assign dc_out_misaligned = dc_en && misaligned_s;

   assign cache.c_req_valid = valid_q;
   assign cache.c_req_addr  = addr_q;
   assign cache.c_req_write = write_q;
   assign cache.c_req_wdata = wdata_q;
   assign cache.c_req_wstrb = strb_q;
   assign dc_out_rdata      = rdata_q;
   assign dc_out_rvalid     = rvalid_q;
   assign dc_out_write_done = wdone_q;

   // Next-state, request capture and registered-output computation.
   always_comb begin
      state_d     = state_q;
      abort_d     = abort_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      strb_d      = strb_q;
      rdata_d     = rdata_q;
      capture_s   = 1'b0;
      // A drop of dc_en in the response cycle itself also counts as abort.
      abort_now_s = abort_q || !dc_en;

      case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (dc_en && !misaligned_s) begin
               capture_s = 1'b1;
               state_d   = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            abort_d = abort_now_s;
            if (cache.c_req_ready) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (cache.c_resp_valid) begin
               abort_d = 1'b0;
               if (abort_now_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
                  if (!write_q) begin
                     rdata_d = cache.c_resp_rdata;
                  end else begin
                     rdata_d = rdata_q;
                  end
               end
            end else begin
               abort_d = abort_now_s;
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            if (advance || !dc_en) begin
               state_d = S_IDLE;
            end else if (dc_write_en != write_q) begin
               // Read-then-write of an atomic: a fresh request, same slot.
               if (misaligned_s) begin
                  state_d = S_IDLE;
               end else begin
                  capture_s = 1'b1;
                  state_d   = S_REQ;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            abort_d = 1'b0;
         end
      endcase

      if (capture_s) begin
         addr_d  = {dc_in_addr[ADDR_WIDTH-1:3], 3'b000};
         write_d = dc_write_en;
         wdata_d = dc_in_wdata << {dc_in_addr[2:0], 3'b000};
         if (dc_write_en) begin
            strb_d = byte_strb(dc_in_wlen, dc_in_addr[2:0]);
         end else begin
            strb_d = {STRB_WIDTH{1'b0}};
         end
      end else begin
         addr_d  = addr_q;
         write_d = write_q;
         wdata_d = wdata_q;
         strb_d  = strb_q;
      end

      valid_d  = (state_d == S_REQ);
      rvalid_d = (state_d == S_DONE) && !write_d;
      wdone_d  = (state_d == S_DONE) && write_d;
   end

   // State, captured request and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         abort_q  <= 1'b0;
         addr_q   <= {ADDR_WIDTH{1'b0}};
         write_q  <= 1'b0;
         wdata_q  <= {DATA_WIDTH{1'b0}};
         strb_q   <= {STRB_WIDTH{1'b0}};
         rdata_q  <= {DATA_WIDTH{1'b0}};
         valid_q  <= 1'b0;
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         abort_q  <= abort_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
         rvalid_q <= rvalid_d;
         wdone_q  <= wdone_d;
      end
   end

endmodule

// File: tb/tb_dcache_req_adapter.sv
// Directed bench for dcache_req_adapter: a per-cycle vector table for load,
// byte store, backpressure and misalignment, then hand-written sequences for
// the atomic read-then-write and the abort cases.
module tb_dcache_req_adapter;

   logic        clk = 1'b0;
   logic        reset;
   logic        dc_en;
   logic [63:0] dc_in_addr;
   logic        dc_write_en;
   logic [63:0] dc_in_wdata;
   logic [1:0]  dc_in_wlen;
   logic        advance;
   logic [63:0] dc_out_rdata;
   logic        dc_out_rvalid;
   logic        dc_out_write_done;
   logic        dc_out_misaligned;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_cnt   = 0;

   dcache_req_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) cif ();

   dcache_req_adapter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk               (clk),
      .reset             (reset),
      .dc_en             (dc_en),
      .dc_in_addr        (dc_in_addr),
      .dc_write_en       (dc_write_en),
      .dc_in_wdata       (dc_in_wdata),
      .dc_in_wlen        (dc_in_wlen),
      .advance           (advance),
      .dc_out_rdata      (dc_out_rdata),
      .dc_out_rvalid     (dc_out_rvalid),
      .dc_out_write_done (dc_out_write_done),
      .dc_out_misaligned (dc_out_misaligned),
      .cache             (cif)
   );

   always #5 clk = ~clk;

   // Count accepted cache handshakes.
   always @(posedge clk) begin
      if (!reset && cif.c_req_valid && cif.c_req_ready) hs_cnt <= hs_cnt + 1;
   end

   typedef struct {
      logic        en;
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [1:0]  wlen;
      logic        adv;
      logic        rdy;
      logic        rsp;
      logic [63:0] rsp_data;
      logic        e_valid;
      logic        e_write;
      logic [63:0] e_addr;
      logic [63:0] e_wdata;
      logic [7:0]  e_strb;
      logic        e_rvalid;
      logic        e_wdone;
      logic        e_mis;
      logic [63:0] e_rdata;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [63:0] addr, input logic we,
                        input logic [63:0] wdata, input logic [1:0] wlen, input logic adv,
                        input logic rdy, input logic rsp, input logic [63:0] rsp_data);
      dc_en            = en;
      dc_in_addr       = addr;
      dc_write_en      = we;
      dc_in_wdata      = wdata;
      dc_in_wlen       = wlen;
      advance          = adv;
      cif.c_req_ready  = rdy;
      cif.c_resp_valid = rsp;
      cif.c_resp_rdata = rsp_data;
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] r1;
      logic        found;
      r1 = 64'h1122_3344_5566_7788;

      //             en    addr          we    wdata                  wlen  adv   rdy   rsp   rsp_data | valid write e_addr        e_wdata                 strb   rv    wd    mis   rdata
      vecs[0]  = '{1'b1, 64'h1000, 1'b0, 64'h0,                 2'd3, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, 64'h0};
      vecs[1]  = '{1'b1, 64'h1000, 1'b0, 64'h0,                 2'd3, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h1000, 64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, 64'h0};
      vecs[2]  = '{1'b1, 64'h1000, 1'b0, 64'h0,                 2'd3, 1'b0, 1'b1, 1'b1, r1,    1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, 64'h0};
      vecs[3]  = '{1'b1, 64'h1000, 1'b0, 64'h0,                 2'd3, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b1, 1'b0, 1'b0, r1};
      vecs[4]  = '{1'b1, 64'h1000, 1'b0, 64'h0,                 2'd3, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b1, 1'b0, 1'b0, r1};
      vecs[5]  = '{1'b0, 64'h0,    1'b0, 64'h0,                 2'd0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      vecs[6]  = '{1'b1, 64'h2005, 1'b1, 64'hAB,                2'd0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      vecs[7]  = '{1'b1, 64'h2005, 1'b1, 64'hAB,                2'd0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h2000, 64'h0000_AB00_0000_0000, 8'h20, 1'b0, 1'b0, 1'b0, r1};
      vecs[8]  = '{1'b1, 64'h2005, 1'b1, 64'hAB,                2'd0, 1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      vecs[9]  = '{1'b1, 64'h2005, 1'b1, 64'hAB,                2'd0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b1, 1'b0, r1};
      vecs[10] = '{1'b0, 64'h0,    1'b0, 64'h0,                 2'd0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      vecs[11] = '{1'b1, 64'h4014, 1'b1, 64'hDEAD_BEEF,         2'd2, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      for (int i = 12; i <= 15; i++)
         vecs[i] = '{1'b1, 64'h4014, 1'b1, 64'hDEAD_BEEF,      2'd2, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h4010, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0, 1'b0, 1'b0, r1};
      vecs[16] = '{1'b1, 64'h4014, 1'b1, 64'hDEAD_BEEF,         2'd2, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h4010, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0, 1'b0, 1'b0, r1};
      vecs[17] = '{1'b1, 64'h4014, 1'b1, 64'hDEAD_BEEF,         2'd2, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      vecs[18] = '{1'b1, 64'h4014, 1'b1, 64'hDEAD_BEEF,         2'd2, 1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      vecs[19] = '{1'b1, 64'h4014, 1'b1, 64'hDEAD_BEEF,         2'd2, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b1, 1'b0, r1};
      vecs[20] = '{1'b0, 64'h0,    1'b0, 64'h0,                 2'd0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};
      vecs[21] = '{1'b1, 64'h3002, 1'b0, 64'h0,                 2'd2, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b1, r1};
      vecs[22] = '{1'b1, 64'h3002, 1'b0, 64'h0,                 2'd2, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b1, r1};
      vecs[23] = '{1'b0, 64'h0,    1'b0, 64'h0,                 2'd0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, r1};

      // Reset state.
      reset = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0);
      repeat (3) @(negedge clk);
      chk("reset_valid",  {63'h0, cif.c_req_valid}, 64'h0);
      chk("reset_rvalid", {63'h0, dc_out_rvalid}, 64'h0);
      chk("reset_wdone",  {63'h0, dc_out_write_done}, 64'h0);
      chk("reset_mis",    {63'h0, dc_out_misaligned}, 64'h0);
      chk("reset_rdata",  dc_out_rdata, 64'h0);
      reset = 1'b0;

      // Per-cycle vector table.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].en, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].wlen,
               vecs[i].adv, vecs[i].rdy, vecs[i].rsp, vecs[i].rsp_data);
         #1;
         chk($sformatf("v%0d_valid", i),  {63'h0, cif.c_req_valid}, {63'h0, vecs[i].e_valid});
         chk($sformatf("v%0d_rvalid", i), {63'h0, dc_out_rvalid}, {63'h0, vecs[i].e_rvalid});
         chk($sformatf("v%0d_wdone", i),  {63'h0, dc_out_write_done}, {63'h0, vecs[i].e_wdone});
         chk($sformatf("v%0d_mis", i),    {63'h0, dc_out_misaligned}, {63'h0, vecs[i].e_mis});
         chk($sformatf("v%0d_rdata", i),  dc_out_rdata, vecs[i].e_rdata);
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d_addr", i),  cif.c_req_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_write", i), {63'h0, cif.c_req_write}, {63'h0, vecs[i].e_write});
            chk($sformatf("v%0d_wdata", i), cif.c_req_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_wstrb", i), {56'h0, cif.c_req_wstrb}, {56'h0, vecs[i].e_strb});
         end
         @(negedge clk);
      end
      chk("table_handshakes", 64'(hs_cnt), 64'd3);

      // Atomic: read completes, then write_en rises on the same address.
      drive(1'b1, 64'h5008, 1'b0, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0, 64'h0);
      @(negedge clk);
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (cif.c_req_valid) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("atomic_rd_req_seen", {63'h0, found}, 64'h1);
      chk("atomic_rd_write",    {63'h0, cif.c_req_write}, 64'h0);
      @(negedge clk);
      cif.c_resp_valid = 1'b1;
      cif.c_resp_rdata = 64'hCAFE_F00D_1234_5678;
      @(negedge clk);
      cif.c_resp_valid = 1'b0;
      #1;
      chk("atomic_rvalid",  {63'h0, dc_out_rvalid}, 64'h1);
      chk("atomic_rdata",   dc_out_rdata, 64'hCAFE_F00D_1234_5678);
      @(negedge clk);
      #1;
      chk("atomic_rvalid_hold", {63'h0, dc_out_rvalid}, 64'h1);
      dc_write_en = 1'b1;
      dc_in_wdata = 64'h55;
      @(negedge clk);
      #1;
      chk("atomic_wr_valid",  {63'h0, cif.c_req_valid}, 64'h1);
      chk("atomic_wr_write",  {63'h0, cif.c_req_write}, 64'h1);
      chk("atomic_wr_addr",   cif.c_req_addr, 64'h5008);
      chk("atomic_wr_wdata",  cif.c_req_wdata, 64'h55);
      chk("atomic_wr_wstrb",  {56'h0, cif.c_req_wstrb}, 64'hFF);
      chk("atomic_rvalid_drop", {63'h0, dc_out_rvalid}, 64'h0);
      @(negedge clk);
      cif.c_resp_valid = 1'b1;
      cif.c_resp_rdata = 64'h9999;
      @(negedge clk);
      cif.c_resp_valid = 1'b0;
      #1;
      chk("atomic_wdone",       {63'h0, dc_out_write_done}, 64'h1);
      chk("atomic_wr_rvalid",   {63'h0, dc_out_rvalid}, 64'h0);
      chk("atomic_rdata_kept",  dc_out_rdata, 64'hCAFE_F00D_1234_5678);
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      dc_en   = 1'b0;
      #1;
      chk("atomic_wdone_drop",  {63'h0, dc_out_write_done}, 64'h0);
      @(negedge clk);

      // Abort: dc_en drops in WAIT; response swallowed; re-request after IDLE.
      drive(1'b1, 64'h6000, 1'b0, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0, 64'h0);
      @(negedge clk);
      #1;
      chk("abort_req_valid", {63'h0, cif.c_req_valid}, 64'h1);
      @(negedge clk);
      dc_en = 1'b0;
      #1;
      chk("abort_wait_valid", {63'h0, cif.c_req_valid}, 64'h0);
      @(negedge clk);
      dc_en            = 1'b1;
      cif.c_resp_valid = 1'b1;
      cif.c_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      chk("abort_rsp_valid",  {63'h0, cif.c_req_valid}, 64'h0);
      @(negedge clk);
      cif.c_resp_valid = 1'b0;
      #1;
      chk("abort_no_rvalid",  {63'h0, dc_out_rvalid}, 64'h0);
      chk("abort_idle_valid", {63'h0, cif.c_req_valid}, 64'h0);
      chk("abort_rdata_kept", dc_out_rdata, 64'hCAFE_F00D_1234_5678);
      @(negedge clk);
      #1;
      chk("abort_reissue_valid", {63'h0, cif.c_req_valid}, 64'h1);
      chk("abort_reissue_addr",  cif.c_req_addr, 64'h6000);
      @(negedge clk);
      cif.c_resp_valid = 1'b1;
      cif.c_resp_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
      @(negedge clk);
      cif.c_resp_valid = 1'b0;
      #1;
      chk("abort_after_rvalid", {63'h0, dc_out_rvalid}, 64'h1);
      chk("abort_after_rdata",  dc_out_rdata, 64'h0F0F_0F0F_0F0F_0F0F);
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      dc_en   = 1'b0;
      #1;
      chk("abort_after_drop", {63'h0, dc_out_rvalid}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
